// File: rtl/snn_pkg.sv
// Types and helpers shared by the spiking-network blocks: decoder FSM states
// and the saturating counter increment used by the neuron counters.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } dec_state_t;

  // Increment `count` unless it already holds the all-ones value of a `width`-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (count >= max_val) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// NUM_NEURONS saturating spike counters with synchronous clear and a single
// read port selected by index, used by the decoder's sequential argmax scan.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic [IDX_WIDTH-1:0]   rd_idx,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_NEURONS];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (enable && spike_in[i]) begin
        cnt_d[i] = COUNT_WIDTH'(sat_inc(32'(cnt_q[i]), COUNT_WIDTH));
      end
    end
  end

  // NOTE: the counters are a handful of flops, not a RAM, so they are reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare-based mux stays in range even when NUM_NEURONS is not a power of two.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) rd_count = cnt_q[i];
    end
  end

endmodule

// File: rtl/spike_count_decoder.sv
// Rate-coded output stage: counts spikes per neuron over a window, scans the
// counts for the argmax (ties go to the lower index) and offers it on valid/ready.
module spike_count_decoder
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WINDOW      = 100,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_WIDTH-1:0]   class_out,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   no_spike
);

  localparam int                 WIN_W     = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_NEURONS - 1);

  dec_state_t             state_q, state_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [IDX_WIDTH-1:0]   scan_idx_q, scan_idx_d;
  logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_WIDTH-1:0]   class_q, class_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic                   no_spike_q, no_spike_d;

  logic                   cnt_clear;
  logic                   cnt_en;
  logic [COUNT_WIDTH-1:0] rd_count;

  spike_counter_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .COUNT_WIDTH (COUNT_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .spike_in (spike_in),
    .rd_idx   (scan_idx_q),
    .rd_count (rd_count)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    class_d    = class_q;
    max_d      = max_q;
    no_spike_d = no_spike_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          win_d     = '0;
          state_d   = COUNT;
        end
      end

      COUNT: begin
        cnt_en = 1'b1;
        win_d  = win_q + 1'b1;
        if (win_q == WIN_LAST) begin
          scan_idx_d = '0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // Step 0 seeds the running best; later steps replace it only on a strictly larger count.
        if (scan_idx_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = rd_count;
        end else if (rd_count > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = rd_count;
        end

        if (scan_idx_q == IDX_LAST) begin
          class_d    = best_idx_d;
          max_d      = best_cnt_d;
          no_spike_d = (best_cnt_d == '0);
          state_d    = DONE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end

      DONE: begin
        if (result_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      class_q    <= '0;
      max_q      <= '0;
      no_spike_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      class_q    <= class_d;
      max_q      <= max_d;
      no_spike_q <= no_spike_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign class_out    = class_q;
  assign max_count    = max_q;
  assign no_spike     = no_spike_q;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Randomised and directed bench for spike_count_decoder; two instances cover a
// wide-counter window of 10 and a 3-bit saturating window of 20.
module tb_spike_count_decoder;

  localparam int N   = 4;
  localparam int WA  = 10;
  localparam int WB  = 20;
  localparam int CWA = 16;
  localparam int CWB = 3;
  localparam int IW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_a, start_b;
  logic [N-1:0]   spk_a, spk_b;
  logic           ready_a, ready_b;
  logic           busy_a, busy_b, valid_a, valid_b, ns_a, ns_b;
  logic [IW-1:0]  cls_a, cls_b;
  logic [CWA-1:0] max_a;
  logic [CWB-1:0] max_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] stim [WB];

  spike_count_decoder #(.NUM_NEURONS(N), .WINDOW(WA), .COUNT_WIDTH(CWA), .IDX_WIDTH(IW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .spike_in(spk_a), .busy(busy_a),
    .result_valid(valid_a), .result_ready(ready_a), .class_out(cls_a),
    .max_count(max_a), .no_spike(ns_a)
  );

  spike_count_decoder #(.NUM_NEURONS(N), .WINDOW(WB), .COUNT_WIDTH(CWB), .IDX_WIDTH(IW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .spike_in(spk_b), .busy(busy_b),
    .result_valid(valid_b), .result_ready(ready_b), .class_out(cls_b),
    .max_count(max_b), .no_spike(ns_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_busy(input bit b);  return b ? 32'(busy_b)  : 32'(busy_a);  endfunction
  function automatic logic [31:0] get_valid(input bit b); return b ? 32'(valid_b) : 32'(valid_a); endfunction
  function automatic logic [31:0] get_cls(input bit b);   return b ? 32'(cls_b)   : 32'(cls_a);   endfunction
  function automatic logic [31:0] get_max(input bit b);   return b ? 32'(max_b)   : 32'(max_a);   endfunction
  function automatic logic [31:0] get_ns(input bit b);    return b ? 32'(ns_b)    : 32'(ns_a);    endfunction

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v; else start_a = v;
  endtask

  task automatic set_spk(input bit b, input logic [N-1:0] v);
    if (b) spk_b = v; else spk_a = v;
  endtask

  task automatic set_ready(input bit b, input logic v);
    if (b) ready_b = v; else ready_a = v;
  endtask

  // Reference: tally the first w stimulus vectors with a saturating cap, then take the lowest-index maximum.
  function automatic void model(input int w, input int cw, output int cls, output int mx, output int ns);
    int cnt [N];
    int cap;
    cap = (1 << cw) - 1;
    foreach (cnt[i]) cnt[i] = 0;
    for (int t = 0; t < w; t++)
      for (int i = 0; i < N; i++)
        if (stim[t][i] && cnt[i] < cap) cnt[i]++;
    cls = 0;
    mx  = cnt[0];
    for (int i = 1; i < N; i++)
      if (cnt[i] > mx) begin cls = i; mx = cnt[i]; end
    ns = (mx == 0) ? 1 : 0;
  endfunction

  task automatic fill_random(input int w);
    int dens [N];
    foreach (dens[i]) dens[i] = $urandom_range(100);
    for (int t = 0; t < WB; t++)
      for (int i = 0; i < N; i++)
        stim[t][i] = ($urandom_range(99) < dens[i]);
  endtask

  // Start a window, feed stim, wait for the result and check latency and result fields.
  task automatic run_window(input bit b, input string name, output int e_cls, output int e_max, output int e_ns);
    int w, cw, lat;
    w  = b ? WB : WA;
    cw = b ? CWB : CWA;
    model(w, cw, e_cls, e_max, e_ns);
    set_ready(b, 1'b0);
    set_start(b, 1'b1);
    set_spk(b, N'($urandom));
    tick();
    set_start(b, 1'b0);
    for (int k = 0; k < w; k++) begin
      set_spk(b, stim[k]);
      tick();
    end
    set_spk(b, N'($urandom));
    n_checks++;
    if (get_busy(b) !== 1 || get_valid(b) !== 0) begin
      n_fail++;
      $display("FAIL %s busy_after_window: busy=%0d valid=%0d required busy=1 valid=0", name, get_busy(b), get_valid(b));
    end
    lat = w;
    while (get_valid(b) !== 1 && lat < 200) begin
      set_spk(b, N'($urandom));
      tick();
      lat++;
    end
    n_checks++;
    if (lat + 1 != 1 + w + N) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat + 1, 1 + w + N);
    end
    n_checks++;
    if (get_cls(b) !== 32'(e_cls)) begin
      n_fail++;
      $display("FAIL %s class_out: got %0d required %0d", name, get_cls(b), e_cls);
    end
    n_checks++;
    if (get_max(b) !== 32'(e_max)) begin
      n_fail++;
      $display("FAIL %s max_count: got %0d required %0d", name, get_max(b), e_max);
    end
    n_checks++;
    if (get_ns(b) !== 32'(e_ns)) begin
      n_fail++;
      $display("FAIL %s no_spike: got %0d required %0d", name, get_ns(b), e_ns);
    end
  endtask

  task automatic accept(input bit b, input string name);
    set_ready(b, 1'b1);
    tick();
    set_ready(b, 1'b0);
    n_checks++;
    if (get_valid(b) !== 0 || get_busy(b) !== 0) begin
      n_fail++;
      $display("FAIL %s accept: valid=%0d busy=%0d required 0 0", name, get_valid(b), get_busy(b));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int b = 0; b < 2; b++) begin
      n_checks++;
      if (get_busy(b[0]) !== 0 || get_valid(b[0]) !== 0 || get_cls(b[0]) !== 0 ||
          get_max(b[0]) !== 0 || get_ns(b[0]) !== 0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: busy=%0d valid=%0d cls=%0d max=%0d ns=%0d required all 0", b,
                 get_busy(b[0]), get_valid(b[0]), get_cls(b[0]), get_max(b[0]), get_ns(b[0]));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int c, m, z;
    for (int t = 0; t < WB; t++) stim[t] = 4'b0100 | ((t % 2 == 0) ? 4'b0010 : 4'b0000);
    run_window(1'b0, "rate", c, m, z);
    n_checks++;
    if (c != 2 || m != 10 || z != 0) begin
      n_fail++;
      $display("FAIL rate_model: got cls=%0d max=%0d ns=%0d required 2 10 0", c, m, z);
    end
    accept(1'b0, "rate");
    for (int t = 0; t < WB; t++) stim[t] = '0;
    run_window(1'b0, "all_zero", c, m, z);
    accept(1'b0, "all_zero");
    for (int t = 0; t < WB; t++) stim[t] = (t % 2 == 0) ? 4'b0010 : 4'b1000;
    run_window(1'b0, "tie", c, m, z);
    accept(1'b0, "tie");
  endtask

  task automatic test_saturation();
    int c, m, z;
    fill_random(WB);
    for (int t = 0; t < WB; t++) stim[t][0] = 1'b1;
    run_window(1'b1, "saturate", c, m, z);
    accept(1'b1, "saturate");
  endtask

  task automatic test_random();
    int c, m, z;
    for (int r = 0; r < 10; r++) begin
      fill_random(WB);
      run_window(r[0], "random", c, m, z);
      accept(r[0], "random");
    end
  endtask

  task automatic test_hold_and_back_to_back();
    int c, m, z;
    fill_random(WB);
    run_window(1'b0, "hold", c, m, z);
    for (int k = 0; k < 8; k++) begin
      start_a = (k == 3);
      spk_a   = N'($urandom);
      tick();
      n_checks++;
      if (valid_a !== 1'b1 || 32'(cls_a) !== 32'(c) || 32'(max_a) !== 32'(m) || 32'(ns_a) !== 32'(z)) begin
        n_fail++;
        $display("FAIL hold cycle %0d: valid=%0d cls=%0d max=%0d ns=%0d required 1 %0d %0d %0d",
                 k, valid_a, cls_a, max_a, ns_a, c, m, z);
      end
    end
    start_a = 1'b0;
    accept(1'b0, "hold");
    n_checks++;
    if (32'(cls_a) !== 32'(c) || 32'(max_a) !== 32'(m)) begin
      n_fail++;
      $display("FAIL idle_keeps_result: cls=%0d max=%0d required %0d %0d", cls_a, max_a, c, m);
    end
    fill_random(WB);
    run_window(1'b0, "back_to_back", c, m, z);
    accept(1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_window();
    int c, m, z;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    spk_a   = 4'b1000;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || cls_a !== '0 || max_a !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%0d valid=%0d cls=%0d max=%0d required all 0", busy_a, valid_a, cls_a, max_a);
    end
    for (int t = 0; t < WB; t++) stim[t] = '0;
    stim[1] = 4'b0001; stim[4] = 4'b0101; stim[7] = 4'b0101;
    run_window(1'b0, "after_reset", c, m, z);
    accept(1'b0, "after_reset");
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    spk_a   = '0;   spk_b   = '0;
    ready_a = 1'b0; ready_b = 1'b0;
    test_reset();
    test_directed();
    test_saturation();
    test_random();
    test_hold_and_back_to_back();
    test_reset_mid_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
